serial_mult_unit: RTL and testbench

- Shift-add sequential multiplier stage feeding the team's load-enabled result register.
- Captures two unsigned operands on a start request and iterates one multiplier bit per clock.
- On completion, presents the product together with a one-cycle load strobe that the downstream register uses as its ld input.
- Includes its own controller FSM and counter; standalone handshake is start/busy/done.

---
 rtl/serial_mult_unit.sv | 75 +++++++
 tb/tb_serial_mult_unit.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/serial_mult_unit.sv
// Shift-add sequential multiplier: one multiplier bit per clock, product
// presented with a one-cycle load strobe for the downstream result register.
module serial_mult_unit #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   inA,
    input  logic [WIDTH-1:0]   inB,
    output logic               busy,
    output logic               done,
    output logic               resultLd,
    output logic [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_hi;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   sum;
    logic             last;

    // carry lands in sum[WIDTH] so the right shift of {carry, accHi, B} is a slice
    always_comb begin
        sum  = b_q[0] ? ({1'b0, acc_hi} + {1'b0, a_q}) : {1'b0, acc_hi};
        last = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_hi  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        a_q     <= inA;
                        b_q     <= inB;
                        acc_hi  <= '0;
                        cnt     <= '0;
                        product <= '0;
                    end
                end
                LOAD: state <= CALC;
                CALC: begin
                    acc_hi <= sum[WIDTH:1];
                    b_q    <= {sum[0], b_q[WIDTH-1:1]};
                    cnt    <= cnt + 1'b1;
                    // capture the final shifted value so product is valid throughout DONE
                    if (last) begin
                        state   <= DONE;
                        product <= {sum[WIDTH:1], sum[0], b_q[WIDTH-1:1]};
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == LOAD) || (state == CALC);
    assign done     = (state == DONE);
    assign resultLd = (state == DONE);

endmodule

// File: tb/tb_serial_mult_unit.sv
// Directed plus random bench for serial_mult_unit; expected products come from
// plain multiplication and expected handshake timing from the cycle counts.
module tb_serial_mult_unit;

    localparam int W3 = 3;
    localparam int W8 = 8;

    logic clk;
    logic rst;
    logic start3, start8;
    logic [W3-1:0] a3, b3;
    logic [W8-1:0] a8, b8;
    logic busy3, done3, ld3, busy8, done8, ld8;
    logic [2*W3-1:0] prod3;
    logic [2*W8-1:0] prod8;
    logic [2*W8-1:0] dreg8;

    int n_checks = 0;
    int n_fail   = 0;

    serial_mult_unit #(.WIDTH(W3), .CNT_W(2)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .inA(a3), .inB(b3),
        .busy(busy3), .done(done3), .resultLd(ld3), .product(prod3)
    );

    serial_mult_unit #(.WIDTH(W8), .CNT_W(3)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .inA(a8), .inB(b8),
        .busy(busy8), .done(done8), .resultLd(ld8), .product(prod8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // downstream load-enabled result register
    always @(posedge clk or negedge rst) begin
        if (!rst) dreg8 <= '0;
        else if (ld8) dreg8 <= prod8;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One WIDTH=3 operation starting at the next edge. hold keeps start high
    // afterwards; poke re-asserts start with (7,7) for one edge in that cycle.
    task automatic op3(input logic [W3-1:0] a, input logic [W3-1:0] b,
                       input bit hold, input int poke);
        logic [31:0] exp;
        exp = 32'(a) * 32'(b);
        @(negedge clk);
        start3 = 1'b1; a3 = a; b3 = b;
        @(posedge clk); #1;
        check("busy_load", 32'(busy3), 1);
        check("done_load", 32'(done3), 0);
        if (!hold) begin
            start3 = 1'b0;
            a3 = W3'($urandom);
            b3 = W3'($urandom);
        end
        for (int k = 1; k <= W3 + 2; k++) begin
            @(posedge clk); #1;
            if (!hold) start3 = 1'b0;
            check("busy", 32'(busy3), (k <= W3) ? 1 : 0);
            check("done", 32'(done3), (k == W3 + 1) ? 1 : 0);
            check("resultLd", 32'(ld3), (k == W3 + 1) ? 1 : 0);
            if (k >= W3 + 1) check("product", 32'(prod3), exp);
            if (k == poke) begin
                start3 = 1'b1; a3 = 3'd7; b3 = 3'd7;
            end
        end
    endtask

    task automatic op8(input logic [W8-1:0] a, input logic [W8-1:0] b);
        logic [31:0] exp;
        exp = 32'(a) * 32'(b);
        @(negedge clk);
        start8 = 1'b1; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = W8'($urandom);
        b8 = W8'($urandom);
        for (int k = 1; k <= W8 + 2; k++) begin
            @(posedge clk); #1;
            check("done8", 32'(done8), (k == W8 + 1) ? 1 : 0);
            check("busy8", 32'(busy8), (k <= W8) ? 1 : 0);
            if (k == W8 + 1) check("product8", 32'(prod8), exp);
        end
        check("dreg8", 32'(dreg8), exp);
    endtask

    initial begin
        rst = 1'b0;
        start3 = 1'b0; start8 = 1'b0;
        a3 = '0; b3 = '0; a8 = '0; b8 = '0;
        #12;
        check("rst_busy", 32'(busy3), 0);
        check("rst_done", 32'(done3), 0);
        check("rst_ld", 32'(ld3), 0);
        check("rst_prod", 32'(prod3), 0);
        check("rst_prod8", 32'(prod8), 0);
        @(negedge clk);
        rst = 1'b1;

        op3(3'd5, 3'd3, 1'b0, -1);
        op3(3'd7, 3'd7, 1'b0, -1);
        op3(3'd0, 3'd6, 1'b0, -1);

        // start pulsed mid-CALC is ignored
        op3(3'd2, 3'd3, 1'b0, 2);
        // held start: back-to-back operations
        op3(3'd4, 3'd4, 1'b1, -1);
        op3(3'd4, 3'd4, 1'b0, -1);

        // asynchronous reset in the second CALC cycle
        @(negedge clk);
        start3 = 1'b1; a3 = 3'd6; b3 = 3'd5;
        @(posedge clk); #1;
        start3 = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy3), 0);
        check("mid_rst_done", 32'(done3), 0);
        check("mid_rst_ld", 32'(ld3), 0);
        check("mid_rst_prod", 32'(prod3), 0);
        @(negedge clk);
        rst = 1'b1;
        op3(3'd3, 3'd2, 1'b0, -1);

        for (int i = 0; i < 12; i++)
            op3(W3'($urandom), W3'($urandom), 1'b0, -1);

        op8(8'd255, 8'd255);
        for (int i = 0; i < 6; i++)
            op8(W8'($urandom), W8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
